// File: rtl/fifo_mem_prog_if.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_mem_prog_if
//  Brief    : Producer/consumer and status bundle for fifo_mem_prog.
//  Revision : 1.0 - initial release
// ============================================================================
interface fifo_mem_prog_if #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                  trans_write;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  trans_read;
    logic [DATA_WIDTH-1:0] data_out;
    logic [CNT_W-1:0]      thresh_level;
    logic                  clr_err;
    logic [CNT_W-1:0]      fill_count;
    logic                  full_ind;
    logic                  empty_ind;
    logic                  overflow_ind;
    logic                  underflow_ind;
    logic                  threshold_ind;

    modport master (
        output trans_write, data_in, trans_read, thresh_level, clr_err,
        input  data_out, fill_count, full_ind, empty_ind,
               overflow_ind, underflow_ind, threshold_ind
    );

    modport slave (
        input  trans_write, data_in, trans_read, thresh_level, clr_err,
        output data_out, fill_count, full_ind, empty_ind,
               overflow_ind, underflow_ind, threshold_ind
    );
endinterface
`default_nettype wire

// File: rtl/fifo_mem_prog.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_mem_prog
//  Brief    : Single-clock FIFO with optional FWFT read, occupancy count,
//             programmable threshold and software-clearable sticky errors.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_mem_prog #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16,
    parameter int FWFT       = 0
) (
    input  wire logic        clk,
    input  wire logic        areset_b,
    fifo_mem_prog_if.slave   bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [PTR_W-1:0] c_PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_ovf;
    logic                  r_unf;

    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic                  w_wr_rej;
    logic                  w_rd_rej;
    logic [CNT_W-1:0]      w_count_nxt;

    // A read at full frees the slot the same-cycle write lands in; a write
    // into an empty FIFO never makes a same-cycle read legal.
    always_comb begin
        w_rd_acc    = bus.trans_read & ~r_empty;
        w_wr_acc    = bus.trans_write & (~r_full | w_rd_acc);
        w_wr_rej    = bus.trans_write & ~w_wr_acc;
        w_rd_rej    = bus.trans_read & ~w_rd_acc;
        w_count_nxt = r_count;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + c_CNT_ONE;
            2'b01:   w_count_nxt = r_count - c_CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge areset_b) begin
        if (!areset_b) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_CNT_MAX);
            r_empty <= (w_count_nxt == '0);
            // A fresh error outranks a clear in the same cycle.
            r_ovf   <= (r_ovf & ~bus.clr_err) | w_wr_rej;
            r_unf   <= (r_unf & ~bus.clr_err) | w_rd_rej;
        end
    end

    // Storage carries no reset; the pointers alone define valid contents.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= bus.data_in;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.data_out = r_mem[r_rd_ptr];
        end else begin : g_registered
            logic [DATA_WIDTH-1:0] r_data_out;

            always_ff @(posedge clk or negedge areset_b) begin
                if (!areset_b) begin
                    r_data_out <= '0;
                end else if (w_rd_acc) begin
                    r_data_out <= r_mem[r_rd_ptr];
                end
            end

            assign bus.data_out = r_data_out;
        end
    endgenerate

    assign bus.fill_count    = r_count;
    assign bus.full_ind      = r_full;
    assign bus.empty_ind     = r_empty;
    assign bus.overflow_ind  = r_ovf;
    assign bus.underflow_ind = r_unf;
    assign bus.threshold_ind = (r_count >= bus.thresh_level);

endmodule
`default_nettype wire

// File: tb/tb_fifo_mem_prog.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_mem_prog
//  Brief    : Randomised scoreboard bench for fifo_mem_prog (FWFT=0 and FWFT=1).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_mem_prog;
    localparam int DW = 16;
    localparam int DP = 16;

    logic clk;
    logic areset_b;

    int checks;
    int errors;
    int thr;

    logic [DW-1:0] mdl_q [$];
    logic [DW-1:0] exp_q [$];
    logic          m_ovf;
    logic          m_unf;
    logic [DW-1:0] m_dout;

    fifo_mem_prog_if #(.DATA_WIDTH(DW), .DEPTH(DP)) ifa ();
    fifo_mem_prog_if #(.DATA_WIDTH(DW), .DEPTH(DP)) ifb ();

    fifo_mem_prog #(.DATA_WIDTH(DW), .DEPTH(DP), .FWFT(0)) u_reg (
        .clk      (clk),
        .areset_b (areset_b),
        .bus      (ifa)
    );

    fifo_mem_prog #(.DATA_WIDTH(DW), .DEPTH(DP), .FWFT(1)) u_fwft (
        .clk      (clk),
        .areset_b (areset_b),
        .bus      (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_status();
        chk("fill_count", 32'(ifa.fill_count), 32'(mdl_q.size()));
        chk("full_ind", 32'(ifa.full_ind), 32'(mdl_q.size() == DP));
        chk("empty_ind", 32'(ifa.empty_ind), 32'(mdl_q.size() == 0));
        chk("overflow_ind", 32'(ifa.overflow_ind), 32'(m_ovf));
        chk("underflow_ind", 32'(ifa.underflow_ind), 32'(m_unf));
        chk("threshold_ind", 32'(ifa.threshold_ind), 32'(mdl_q.size() >= thr));
        chk("data_out_hold", 32'(ifa.data_out), 32'(m_dout));
    endtask

    // One clock of stimulus on the registered-read instance, with the model
    // deciding acceptance from occupancy alone.
    task automatic step(input bit wr, input logic [DW-1:0] d, input bit rd, input bit clr);
        bit            rd_acc;
        bit            wr_acc;
        logic [DW-1:0] v;
        ifa.trans_write  = wr;
        ifa.data_in      = d;
        ifa.trans_read   = rd;
        ifa.clr_err      = clr;
        ifa.thresh_level = 5'(thr);
        rd_acc = rd && (mdl_q.size() != 0);
        wr_acc = wr && ((mdl_q.size() < DP) || rd_acc);
        if (rd_acc) exp_q.push_back(mdl_q[0]);
        @(posedge clk);
        if (rd_acc) begin
            v      = mdl_q.pop_front();
            m_dout = v;
        end
        if (wr_acc) mdl_q.push_back(d);
        m_ovf = (m_ovf && !clr) || (wr && !wr_acc);
        m_unf = (m_unf && !clr) || (rd && !rd_acc);
        #1;
        ifa.trans_write = 1'b0;
        ifa.trans_read  = 1'b0;
        ifa.clr_err     = 1'b0;
        check_status();
    endtask

    // Monitor: whenever the DUT takes a read, the next data_out must be the
    // oldest outstanding expected word.
    initial begin
        logic [DW-1:0] e;
        forever begin
            @(posedge clk);
            if (areset_b === 1'b1 && ifa.trans_read === 1'b1 && ifa.empty_ind === 1'b0) begin
                #1;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected_read: got data_out %0h expected no read at %0t",
                             ifa.data_out, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_order", 32'(ifa.data_out), 32'(e));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        thr    = 4;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_dout = '0;
        areset_b = 1'b0;
        ifa.trans_write = 1'b0; ifa.trans_read = 1'b0; ifa.clr_err = 1'b0;
        ifa.data_in = '0; ifa.thresh_level = 5'd4;
        ifb.trans_write = 1'b0; ifb.trans_read = 1'b0; ifb.clr_err = 1'b0;
        ifb.data_in = '0; ifb.thresh_level = 5'd0;
        repeat (3) @(negedge clk);
        areset_b = 1'b1;
        @(posedge clk);
        #1;
        check_status();

        // Mid-stream asynchronous reset with 5 entries held.
        for (int i = 0; i < 6; i++) step(1, 16'h0100 + 16'(i), 0, 0);
        step(0, '0, 1, 0);
        #2;
        areset_b = 1'b0;
        #1;
        mdl_q.delete();
        exp_q.delete();
        m_ovf = 1'b0; m_unf = 1'b0; m_dout = '0;
        check_status();
        @(negedge clk);
        @(negedge clk);
        areset_b = 1'b1;
        @(posedge clk);
        #1;
        step(0, '0, 1, 0);
        chk("unf_after_reset", 32'(ifa.underflow_ind), 32'd1);
        step(0, '0, 0, 1);

        // Fill to full, reject a 17th write, drain in order.
        for (int i = 1; i <= DP; i++) step(1, 16'(i), 0, 0);
        chk("full_at_16", 32'(ifa.full_ind), 32'd1);
        step(1, 16'hDEAD, 0, 0);
        chk("ovf_on_17th", 32'(ifa.overflow_ind), 32'd1);
        for (int i = 0; i < DP; i++) step(0, '0, 1, 0);
        chk("dout_last", 32'(ifa.data_out), 32'h0010);

        // Underflow, clear, clear racing a new underflow.
        step(0, '0, 1, 0);
        step(0, '0, 0, 1);
        step(0, '0, 1, 1);
        chk("unf_wins_clear", 32'(ifa.underflow_ind), 32'd1);
        step(0, '0, 0, 1);

        // Simultaneous read and write at full, at 5, and at empty.
        for (int i = 0; i < DP; i++) step(1, 16'h2000 + 16'(i), 0, 0);
        step(1, 16'h2EEE, 1, 0);
        while (mdl_q.size() > 5) step(0, '0, 1, 0);
        step(1, 16'h2555, 1, 0);
        while (mdl_q.size() > 0) step(0, '0, 1, 0);
        step(1, 16'h2111, 1, 0);
        chk("empty_wr_rd_count", 32'(ifa.fill_count), 32'd1);
        step(0, '0, 1, 1);

        // Threshold at 4, then extremes 0 and DEPTH+1.
        thr = 4;
        for (int i = 0; i < 5; i++) step(1, 16'(16'h3000 + i), 0, 0);
        thr = 0;
        step(0, '0, 0, 0);
        thr = DP + 1;
        while (mdl_q.size() < DP) step(1, 16'($urandom), 0, 0);
        thr = 4;
        while (mdl_q.size() > 2) step(0, '0, 1, 0);

        // Interleaved pairs and free-running random traffic across wrap.
        for (int i = 0; i < 40; i++) step(1, 16'($urandom), 1, 0);
        for (int i = 0; i < 200; i++) begin
            if ((i % 37) == 0) thr = int'($urandom_range(0, DP + 2));
            step(($urandom_range(0, 9) < 6), 16'($urandom), $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 7) == 0));
        end
        while (mdl_q.size() > 0) step(0, '0, 1, 0);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d outstanding expected 0", exp_q.size());
        end

        // FWFT instance: head entry visible without a read.
        @(posedge clk);
        #1;
        ifb.trans_write = 1'b1; ifb.data_in = 16'hA5A5;
        @(posedge clk);
        #1;
        ifb.trans_write = 1'b0;
        chk("fwft_empty", 32'(ifb.empty_ind), 32'd0);
        chk("fwft_head", 32'(ifb.data_out), 32'hA5A5);
        ifb.trans_write = 1'b1; ifb.data_in = 16'h5A5A;
        @(posedge clk);
        #1;
        ifb.trans_write = 1'b0;
        chk("fwft_head_kept", 32'(ifb.data_out), 32'hA5A5);
        chk("fwft_count2", 32'(ifb.fill_count), 32'd2);
        ifb.trans_read = 1'b1;
        @(posedge clk);
        #1;
        ifb.trans_read = 1'b0;
        chk("fwft_advance", 32'(ifb.data_out), 32'h5A5A);
        chk("fwft_count1", 32'(ifb.fill_count), 32'd1);
        ifb.trans_read = 1'b1;
        @(posedge clk);
        #1;
        ifb.trans_read = 1'b0;
        chk("fwft_drained", 32'(ifb.empty_ind), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
